// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, signed or
// unsigned operands, start/busy/done handshake. Latency WIDTH+1 edges.
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t         state, state_next;
  logic [PW-1:0]  ma;
  logic [PW-1:0]  acc;
  logic [WIDTH-1:0] mb;
  logic [CW-1:0]  count;
  logic           neg;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             last;

  // The most-negative operand negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign last  = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last)  state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, e.g. acc adds the unshifted ma.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      count <= '0;
      neg   <= 1'b0;
      c     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            ma    <= {{WIDTH{1'b0}}, a_mag};
            mb    <= b_mag;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          if (mb[0]) acc <= acc + ma;
          ma    <= ma << 1;
          mb    <= mb >> 1;
          count <= count + CW'(1);
        end
        FIX: begin
          c    <= neg ? (~acc + PW'(1)) : acc;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq at WIDTH=8 and WIDTH=16: directed cases
// plus randomized traffic, checked through a queue-based scoreboard.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] c8;
  logic        busy8, done8;

  logic        start16 = 1'b0, sgn16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] c16;
  logic        busy16, done16;

  mul_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .c(c8), .busy(busy8), .done(done8)
  );

  mul_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16),
    .a(a16), .b(b16), .c(c16), .busy(busy16), .done(done16)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] sb8[$];
  logic [31:0] sb16[$];
  logic prev8 = 1'b0, prev16 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [15:0] xe, ye;
    xe = s ? {{8{x[7]}}, x} : {8'h00, x};
    ye = s ? {{8{y[7]}}, y} : {8'h00, y};
    return xe * ye;
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [31:0] xe, ye;
    xe = s ? {{16{x[15]}}, x} : {16'h0000, x};
    ye = s ? {{16{y[15]}}, y} : {16'h0000, y};
    return xe * ye;
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'h7F;
      3: return 8'hFF;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  // Output monitors: every done pops one expected product.
  initial begin
    forever begin
      tick();
      if (rst_n && done8) begin
        check("done8_pulse", {31'b0, prev8}, 32'd0);
        check("busy8_with_done", {31'b0, busy8}, 32'd0);
        check("sb8_pending", {31'b0, sb8.size() != 0}, 32'd1);
        if (sb8.size() != 0) check("c8", {16'b0, c8}, {16'b0, sb8.pop_front()});
      end
      prev8 = done8;
    end
  end

  initial begin
    forever begin
      tick();
      if (rst_n && done16) begin
        check("done16_pulse", {31'b0, prev16}, 32'd0);
        check("busy16_with_done", {31'b0, busy16}, 32'd0);
        check("sb16_pending", {31'b0, sb16.size() != 0}, 32'd1);
        if (sb16.size() != 0) check("c16", c16, sb16.pop_front());
      end
      prev16 = done16;
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 40) begin
      tick();
      n++;
    end
    if (busy8) check("idle8_wait", {31'b0, busy8}, 32'd0);
  endtask

  task automatic wait_idle16();
    int n = 0;
    while (busy16 && n < 60) begin
      tick();
      n++;
    end
    if (busy16) check("idle16_wait", {31'b0, busy16}, 32'd0);
  endtask

  // Drives one request, returns just after the accept edge.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic s);
    wait_idle8();
    a8 = av; b8 = bv; sgn8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    sb8.push_back(model8(av, bv, s));
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
  endtask

  task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic s);
    wait_idle16();
    a16 = av; b16 = bv; sgn16 = s; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    sb16.push_back(model16(av, bv, s));
    a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
  endtask

  // Edges until done, plus number of busy-high samples including the current one.
  task automatic wait_done8(output int n, output int bc);
    n = 0;
    bc = busy8 ? 1 : 0;
    do begin
      tick();
      n++;
      if (busy8) bc++;
    end while (!done8 && n < 40);
    check("done8_seen", {31'b0, done8}, 32'd1);
  endtask

  initial begin
    int n, bc;

    #1;
    check("rst_c8", {16'b0, c8}, 32'd0);
    check("rst_busy8", {31'b0, busy8}, 32'd0);
    check("rst_done8", {31'b0, done8}, 32'd0);
    check("rst_c16", c16, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Unsigned max operands, latency and busy width.
    issue8(8'hFF, 8'hFF, 1'b0);
    check("t1_busy_after_accept", {31'b0, busy8}, 32'd1);
    wait_done8(n, bc);
    check("t1_latency", n, 32'd9);
    check("t1_busy_cycles", bc, 32'd9);
    check("t1_c", {16'b0, c8}, 32'h0000FE01);

    // Signed versus unsigned interpretation of the same bits.
    issue8(8'hFD, 8'h07, 1'b1);
    wait_done8(n, bc);
    check("t2_signed", {16'b0, c8}, 32'h0000FFEB);
    issue8(8'hFD, 8'h07, 1'b0);
    wait_done8(n, bc);
    check("t2_unsigned", {16'b0, c8}, 32'h000006EB);

    // Most-negative operand.
    issue8(8'h80, 8'h80, 1'b1);
    wait_done8(n, bc);
    check("t3_minmin", {16'b0, c8}, 32'h00004000);
    issue8(8'h80, 8'h01, 1'b1);
    wait_done8(n, bc);
    check("t3_minone", {16'b0, c8}, 32'h0000FF80);

    // start while busy is ignored.
    issue8(8'd10, 8'd20, 1'b0);
    tick(); tick();
    a8 = 8'd99; b8 = 8'd99; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(n, bc);
    check("t4_ignored_c", {16'b0, c8}, 32'd200);
    repeat (12) tick();

    // start held through done: back-to-back accept.
    a8 = 8'd3; b8 = 8'd4; sgn8 = 1'b0; start8 = 1'b1;
    tick();
    sb8.push_back(16'd12);
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check("t4_first_done", {31'b0, done8}, 32'd1);
    a8 = 8'd7; b8 = 8'd9;
    tick();
    start8 = 1'b0;
    sb8.push_back(16'd63);
    wait_done8(n, bc);
    check("t4_b2b_period", n + 1, 32'd10);
    check("t4_b2b_c", {16'b0, c8}, 32'd63);

    // Reset in the middle of CALC.
    issue8(8'd200, 8'd3, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    sb8.delete();
    check("t5_rst_c", {16'b0, c8}, 32'd0);
    check("t5_rst_busy", {31'b0, busy8}, 32'd0);
    check("t5_rst_done", {31'b0, done8}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    issue8(8'd5, 8'd6, 1'b0);
    wait_done8(n, bc);
    check("t5_after_rst", {16'b0, c8}, 32'd30);

    // Randomized traffic, both widths.
    for (int i = 0; i < 1200; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      issue8(pick8(), pick8(), 1'($urandom));
    end
    wait_idle8();
    repeat (3) tick();

    for (int i = 0; i < 400; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 7) == 0) x = 16'h8000;
      if ($urandom_range(0, 7) == 0) y = 16'hFFFF;
      repeat ($urandom_range(0, 3)) tick();
      issue16(x, y, 1'($urandom));
    end
    wait_idle16();
    repeat (3) tick();

    check("sb8_drained", sb8.size(), 32'd0);
    check("sb16_drained", sb16.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
